// File: rtl/fuzzy_trap_fuzzifier.sv
// Runtime-programmable trapezoidal fuzzifier: streams one membership degree per MF for each sample.
// Optional winner tracking (WinValid/WinIndex/WinDegree, ErrorList[3]) is enabled by HFC_WINNER_EN.
module fuzzy_trap_fuzzifier #(
   parameter int IN_W    = 10,
   parameter int NUM_MF  = 4,
   parameter int DEG_W   = 8,
   parameter int SLOPE_W = 16,
   parameter int FRAC_W  = 8,
   localparam int IDX_W   = (NUM_MF > 1) ? $clog2(NUM_MF) : 1,
   localparam int CFGMF_W = $clog2(NUM_MF) + 1,
   localparam int CFG_W   = (IN_W > SLOPE_W) ? IN_W : SLOPE_W
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               CfgWrEn,
   input  logic [CFGMF_W-1:0] CfgMf,
   input  logic [2:0]         CfgField,
   input  logic [CFG_W-1:0]   CfgData,
   input  logic               InValid,
   output logic               InReady,
   input  logic [IN_W-1:0]    InData,
   output logic               OutValid,
   input  logic               OutReady,
   output logic [DEG_W-1:0]   OutDegree,
   output logic [IDX_W-1:0]   OutIndex,
   output logic               OutLast,
   input  logic               ErrClr,
   output logic [3:0]         ErrorList
`ifdef HFC_WINNER_EN
   ,
   output logic               WinValid,
   output logic [IDX_W-1:0]   WinIndex,
   output logic [DEG_W-1:0]   WinDegree
`endif
);

   localparam int PROD_W = IN_W + SLOPE_W;
   localparam logic [DEG_W-1:0]   DEG_MAX  = '1;
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_MF - 1);
   localparam logic [CFGMF_W-1:0] MF_LIM   = CFGMF_W'(NUM_MF);

   typedef enum logic {IDLE, RUN} stateT;
   stateT state, stateNext;

   logic [IN_W-1:0]    aTab [NUM_MF];
   logic [IN_W-1:0]    bTab [NUM_MF];
   logic [IN_W-1:0]    cTab [NUM_MF];
   logic [IN_W-1:0]    dTab [NUM_MF];
   logic [SLOPE_W-1:0] suTab [NUM_MF];
   logic [SLOPE_W-1:0] sdTab [NUM_MF];

   logic [IN_W-1:0]  xReg;
   logic [IDX_W-1:0] idx;
   logic             sampleAcc, outAcc, loadEn;
   logic             cfgBusy, cfgBad, cfgDo;
   logic [IDX_W-1:0] mfSel;
   logic             orderBad;
   logic [DEG_W-1:0] degree;
   logic             winErr;

   function automatic logic [DEG_W-1:0] satDeg(input logic [PROD_W-1:0] v);
      return (v > PROD_W'(DEG_MAX)) ? DEG_MAX : v[DEG_W-1:0];
   endfunction

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      InReady   = 1'b0;
      case (state)
         IDLE: begin
            InReady = 1'b1;
            if (InValid) stateNext = RUN;
         end
         RUN: begin
            if (OutValid && OutReady && OutLast) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign sampleAcc = (state == IDLE) && InValid;
   assign outAcc    = OutValid && OutReady;
   // No further load once the last MF sits in the output register.
   assign loadEn    = (state == RUN) && (!OutValid || OutReady) && !(OutValid && OutLast);

   assign cfgBusy = CfgWrEn && ((state != IDLE) || InValid);
   assign cfgBad  = CfgWrEn && ((CfgMf >= MF_LIM) || (CfgField > 3'd5));
   assign cfgDo   = CfgWrEn && !cfgBusy && !cfgBad;
   assign mfSel   = CfgMf[IDX_W-1:0];

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int unsigned i = 0; i < NUM_MF; i++) begin
            aTab[i]  <= '0;
            bTab[i]  <= '0;
            cTab[i]  <= '0;
            dTab[i]  <= '0;
            suTab[i] <= '0;
            sdTab[i] <= '0;
         end
      end else if (cfgDo) begin
         case (CfgField)
            3'd0:    aTab[mfSel]  <= CfgData[IN_W-1:0];
            3'd1:    bTab[mfSel]  <= CfgData[IN_W-1:0];
            3'd2:    cTab[mfSel]  <= CfgData[IN_W-1:0];
            3'd3:    dTab[mfSel]  <= CfgData[IN_W-1:0];
            3'd4:    suTab[mfSel] <= CfgData[SLOPE_W-1:0];
            default: sdTab[mfSel] <= CfgData[SLOPE_W-1:0];
         endcase
      end
   end

   always_comb begin
      logic [IN_W-1:0]   selA, selB, selC, selD;
      logic [PROD_W-1:0] riseShift, fallShift;
      selA      = aTab[idx];
      selB      = bTab[idx];
      selC      = cTab[idx];
      selD      = dTab[idx];
      riseShift = (PROD_W'(xReg - selA) * PROD_W'(suTab[idx])) >> FRAC_W;
      fallShift = (PROD_W'(selD - xReg) * PROD_W'(sdTab[idx])) >> FRAC_W;
      orderBad  = (selA > selB) || (selB > selC) || (selC > selD);
      degree    = '0;
      if (orderBad || (xReg < selA) || (xReg > selD)) degree = '0;
      else if (xReg < selB)                           degree = satDeg(riseShift);
      else if (xReg <= selC)                          degree = DEG_MAX;
      else                                            degree = satDeg(fallShift);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         xReg      <= '0;
         idx       <= '0;
         OutValid  <= 1'b0;
         OutDegree <= '0;
         OutIndex  <= '0;
         OutLast   <= 1'b0;
         ErrorList <= '0;
      end else begin
         if (sampleAcc) begin
            xReg <= InData;
            idx  <= '0;
         end
         if (loadEn) begin
            OutValid  <= 1'b1;
            OutDegree <= degree;
            OutIndex  <= idx;
            OutLast   <= (idx == LAST_IDX);
            idx       <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         end else if (outAcc) begin
            OutValid <= 1'b0;
         end
         ErrorList <= (ErrorList & {4{~ErrClr}}) |
                      {winErr, loadEn && orderBad, cfgBad, cfgBusy};
      end
   end

`ifdef HFC_WINNER_EN
   logic [IDX_W-1:0] bestIdx;
   logic [DEG_W-1:0] bestDeg;
   logic             inValidQ;
   logic             takeCur;

   // Strict compare keeps the lowest index on ties; MF0 always seeds the running max.
   assign takeCur = (OutIndex == '0) || (OutDegree > bestDeg);
   assign winErr  = InValid && !inValidQ && WinValid && !InReady;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         bestIdx   <= '0;
         bestDeg   <= '0;
         inValidQ  <= 1'b0;
         WinValid  <= 1'b0;
         WinIndex  <= '0;
         WinDegree <= '0;
      end else begin
         inValidQ <= InValid;
         WinValid <= 1'b0;
         if (outAcc) begin
            if (takeCur) begin
               bestIdx <= OutIndex;
               bestDeg <= OutDegree;
            end
            if (OutLast) begin
               WinValid  <= 1'b1;
               WinIndex  <= takeCur ? OutIndex : bestIdx;
               WinDegree <= takeCur ? OutDegree : bestDeg;
            end
         end
      end
   end
`else
   assign winErr = 1'b0;
`endif

endmodule

// File: tb/tb_fuzzy_trap_fuzzifier.sv
// Directed, table-driven bench for fuzzy_trap_fuzzifier (4 MFs, 10-bit input, 8-bit degree).
module tb_fuzzy_trap_fuzzifier;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        CfgWrEn;
   logic [2:0]  CfgMf;
   logic [2:0]  CfgField;
   logic [15:0] CfgData;
   logic        InValid;
   logic        InReady;
   logic [9:0]  InData;
   logic        OutValid;
   logic        OutReady;
   logic [7:0]  OutDegree;
   logic [1:0]  OutIndex;
   logic        OutLast;
   logic        ErrClr;
   logic [3:0]  ErrorList;
`ifdef HFC_WINNER_EN
   logic        WinValid;
   logic [1:0]  WinIndex;
   logic [7:0]  WinDegree;
`endif

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   fuzzy_trap_fuzzifier #(
      .IN_W(10), .NUM_MF(4), .DEG_W(8), .SLOPE_W(16), .FRAC_W(8)
   ) dut (
      .Clk(Clk), .Rst(Rst),
      .CfgWrEn(CfgWrEn), .CfgMf(CfgMf), .CfgField(CfgField), .CfgData(CfgData),
      .InValid(InValid), .InReady(InReady), .InData(InData),
      .OutValid(OutValid), .OutReady(OutReady), .OutDegree(OutDegree),
      .OutIndex(OutIndex), .OutLast(OutLast),
      .ErrClr(ErrClr), .ErrorList(ErrorList)
`ifdef HFC_WINNER_EN
      , .WinValid(WinValid), .WinIndex(WinIndex), .WinDegree(WinDegree)
`endif
   );

   typedef struct {
      logic [9:0]  x;
      logic [31:0] expv;   // {deg3, deg2, deg1, deg0}
   } vecT;

   vecT vecs [10];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic cfgWrite(input logic [2:0] mf, input logic [2:0] field, input logic [15:0] data);
      @(negedge Clk);
      CfgWrEn  = 1'b1;
      CfgMf    = mf;
      CfgField = field;
      CfgData  = data;
      @(negedge Clk);
      CfgWrEn  = 1'b0;
   endtask

   task automatic setMf(input logic [2:0] mf, input logic [9:0] a, input logic [9:0] b,
                        input logic [9:0] c, input logic [9:0] d,
                        input logic [15:0] su, input logic [15:0] sd);
      cfgWrite(mf, 3'd0, {6'd0, a});
      cfgWrite(mf, 3'd1, {6'd0, b});
      cfgWrite(mf, 3'd2, {6'd0, c});
      cfgWrite(mf, 3'd3, {6'd0, d});
      cfgWrite(mf, 3'd4, su);
      cfgWrite(mf, 3'd5, sd);
   endtask

   task automatic loadT1();
      setMf(3'd0, 10'd0,  10'd1,  10'd2,  10'd3,  16'd65280, 16'd65280);
      setMf(3'd1, 10'd2,  10'd3,  10'd5,  10'd7,  16'd65280, 16'd32640);
      setMf(3'd2, 10'd6,  10'd8,  10'd10, 10'd12, 16'd32640, 16'd32640);
      setMf(3'd3, 10'd11, 10'd14, 10'd16, 10'd20, 16'd21760, 16'd16320);
   endtask

   task automatic pulseClr();
      @(negedge Clk);
      ErrClr = 1'b1;
      @(negedge Clk);
      ErrClr = 1'b0;
   endtask

   // Starts at the negedge after the sample handshake; returns at the negedge after OutLast is taken.
   task automatic collect(input logic [31:0] expv, input logic [3:0] pat, input string name);
      int unsigned nextIdx = 0;
      int unsigned cyc = 0;
      logic        prevStall = 1'b0;
      logic [7:0]  prevDeg = '0;
      logic [1:0]  prevIdx = '0;
      logic [7:0]  wantDeg;
      while (nextIdx < 4 && cyc < 40) begin
         OutReady = pat[cyc % 4];
         if (OutValid) begin
            if (prevStall) begin
               chk({name, "_holdDeg"}, OutDegree, prevDeg);
               chk({name, "_holdIdx"}, OutIndex, prevIdx);
            end
            if (OutReady) begin
               wantDeg = expv[nextIdx*8 +: 8];
               chk({name, "_idx"}, OutIndex, nextIdx);
               chk({name, "_deg"}, OutDegree, wantDeg);
               chk({name, "_last"}, OutLast, nextIdx == 3);
               nextIdx++;
               prevStall = 1'b0;
            end else begin
               prevStall = 1'b1;
            end
            prevDeg = OutDegree;
            prevIdx = OutIndex;
         end
         cyc++;
         @(negedge Clk);
      end
      if (nextIdx < 4) chk({name, "_timeout"}, nextIdx, 4);
      chk({name, "_inReadyAfter"}, InReady, 1'b1);
      chk({name, "_outValidAfter"}, OutValid, 1'b0);
`ifdef HFC_WINNER_EN
      begin
         logic [7:0] bd;
         logic [1:0] bi;
         bd = expv[7:0];
         bi = 2'd0;
         for (int i = 1; i < 4; i++) begin
            if (expv[i*8 +: 8] > bd) begin
               bd = expv[i*8 +: 8];
               bi = 2'(i);
            end
         end
         chk({name, "_winValid"}, WinValid, 1'b1);
         chk({name, "_winIdx"}, WinIndex, bi);
         chk({name, "_winDeg"}, WinDegree, bd);
      end
`endif
   endtask

   task automatic runStream(input logic [9:0] x, input logic [31:0] expv,
                            input logic [3:0] pat, input string name);
      @(negedge Clk);
      InValid  = 1'b1;
      InData   = x;
      OutReady = pat[0];
      @(negedge Clk);
      InValid  = 1'b0;
      chk({name, "_busy"}, InReady, 1'b0);
      collect(expv, pat, name);
   endtask

   initial begin
      Rst = 1'b1; CfgWrEn = 1'b0; CfgMf = '0; CfgField = '0; CfgData = '0;
      InValid = 1'b0; InData = '0; OutReady = 1'b1; ErrClr = 1'b0;

      vecs[0] = '{x: 10'd6,    expv: 32'h0000_7F00};
      vecs[1] = '{x: 10'd4,    expv: 32'h0000_FF00};
      vecs[2] = '{x: 10'd0,    expv: 32'h0000_0000};
      vecs[3] = '{x: 10'd1,    expv: 32'h0000_00FF};
      vecs[4] = '{x: 10'd7,    expv: 32'h007F_0000};
      vecs[5] = '{x: 10'd13,   expv: 32'hAA00_0000};
      vecs[6] = '{x: 10'd18,   expv: 32'h7F00_0000};
      vecs[7] = '{x: 10'd9,    expv: 32'h00FF_0000};
      vecs[8] = '{x: 10'd1023, expv: 32'h0000_0000};
      vecs[9] = '{x: 10'd3,    expv: 32'h0000_FF00};

      repeat (2) @(negedge Clk);
      chk("rst_outValid", OutValid, 1'b0);
      chk("rst_inReady", InReady, 1'b1);
      chk("rst_err", ErrorList, 4'd0);
      chk("rst_deg", OutDegree, 8'd0);
      chk("rst_idx", OutIndex, 2'd0);
      chk("rst_last", OutLast, 1'b0);
      Rst = 1'b0;

      loadT1();
      for (int i = 0; i < 10; i++)
         runStream(vecs[i].x, vecs[i].expv, 4'b1111, $sformatf("vec%0d", i));
      chk("vec_err", ErrorList, 4'd0);

      // Backpressure: ready pattern 1,0,0,1 repeating.
      runStream(10'd7, 32'h007F_0000, 4'b1001, "stall");

      // Config write while streaming is dropped.
      @(negedge Clk);
      InValid = 1'b1; InData = 10'd6; OutReady = 1'b0;
      @(negedge Clk);
      InValid = 1'b0;
      CfgWrEn = 1'b1; CfgMf = 3'd1; CfgField = 3'd3; CfgData = 16'd6;
      @(negedge Clk);
      CfgWrEn = 1'b0;
      collect(32'h0000_7F00, 4'b1111, "busyWr");
      chk("busyWr_err", ErrorList, 4'b0001);
      pulseClr();
      chk("clr_err", ErrorList, 4'd0);
      runStream(10'd6, 32'h0000_7F00, 4'b1111, "busyWrTable");

      // Sample and config write in the same IDLE cycle: sample wins.
      @(negedge Clk);
      InValid = 1'b1; InData = 10'd6; OutReady = 1'b1;
      CfgWrEn = 1'b1; CfgMf = 3'd1; CfgField = 3'd3; CfgData = 16'd6;
      @(negedge Clk);
      InValid = 1'b0; CfgWrEn = 1'b0;
      collect(32'h0000_7F00, 4'b1111, "simul");
      chk("simul_err", ErrorList, 4'b0001);
      pulseClr();
      runStream(10'd6, 32'h0000_7F00, 4'b1111, "simulTable");

      // Illegal field / MF index.
      cfgWrite(3'd0, 3'd6, 16'd5);
      chk("badField_err", ErrorList, 4'b0010);
      pulseClr();
      cfgWrite(3'd4, 3'd0, 16'd5);
      chk("badMf_err", ErrorList, 4'b0010);
      pulseClr();
      runStream(10'd1, 32'h0000_00FF, 4'b1111, "badTable");

      // Order violation on MF1 (B=9 > C=5).
      cfgWrite(3'd1, 3'd1, 16'd9);
      runStream(10'd4, 32'h0000_0000, 4'b1111, "order");
      chk("order_err", ErrorList, 4'b0100);
      cfgWrite(3'd1, 3'd1, 16'd3);
      pulseClr();
      runStream(10'd4, 32'h0000_FF00, 4'b1111, "orderFixed");
      chk("orderFixed_err", ErrorList, 4'd0);

      // Saturation on both slopes.
      setMf(3'd0, 10'd0, 10'd10, 10'd12, 10'd20, 16'hFFFF, 16'd65280);
      runStream(10'd5,  32'h0000_FFFF, 4'b1111, "satUp");
      runStream(10'd15, 32'hFF00_00FF, 4'b1111, "satDn");

      // Asynchronous reset while MF2 is presented.
      begin
         logic found = 1'b0;
         @(negedge Clk);
         InValid = 1'b1; InData = 10'd9; OutReady = 1'b1;
         @(negedge Clk);
         InValid = 1'b0;
         for (int i = 0; i < 10 && !found; i++) begin
            if (OutValid && OutIndex == 2'd2) found = 1'b1;
            else @(negedge Clk);
         end
         chk("midRst_reach", found, 1'b1);
         #2 Rst = 1'b1;
         #1;
         chk("midRst_outValid", OutValid, 1'b0);
         chk("midRst_inReady", InReady, 1'b1);
         chk("midRst_last", OutLast, 1'b0);
         @(negedge Clk);
         Rst = 1'b0;
      end
      runStream(10'd5, 32'h0000_0000, 4'b1111, "postRst");
      chk("postRst_err", ErrorList, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
